// File: rtl/dct2d_quant_stream_if.sv
// Valid/ready streaming bus for the 8x8 DCT/quantiser block: sample input,
// per-block mode pins and coefficient output.
interface dct2d_quant_stream_if #(
    parameter int DW_IN  = 10,
    parameter int DW_OUT = 12
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DW_IN-1:0]  in_data;
    logic                     quant_en;
    logic                     zigzag_en;
    logic [7:0]               qscale;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DW_OUT-1:0] out_data;
    logic                     out_last;

    modport master (
        output in_valid, in_data, quant_en, zigzag_en, qscale, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, quant_en, zigzag_en, qscale, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/dct2d_quant_stream.sv
// Streaming 8x8 2D DCT-II: load 64 samples, row pass, column pass, then drain
// 64 coefficients (raw or JPEG-quantised, raster or zigzag order).
module dct2d_quant_stream #(
    parameter int DW_IN     = 10,
    parameter int DW_OUT    = 12,
    parameter int COEF_FRAC = 12
) (
    input logic                clk,
    input logic                rst,
    dct2d_quant_stream_if.slave bus
);
    localparam int CW   = COEF_FRAC + 2;        // signed cosine coefficient
    localparam int RW   = DW_IN + 3;            // row-pass result
    localparam int XW   = DW_IN + 4;            // column-pass result
    localparam int AW   = RW + CW + 3;          // 8-term accumulator
    localparam int HALF = 1 << (COEF_FRAC - 1);
    localparam int SMAX = (1 << (DW_OUT - 1)) - 1;
    localparam int SMIN = -(1 << (DW_OUT - 1));

    // Rounded magnitude of 2^(COEF_FRAC-1)*cos(m*pi/16); cosines kept as exact
    // 9-digit decimals so the rounding is done in integer arithmetic.
    function automatic longint cmag(input int m);
        longint n;
        case (m)
            0:       n = 64'd1000000000;
            1:       n = 64'd980785280;
            2:       n = 64'd923879533;
            3:       n = 64'd831469612;
            4:       n = 64'd707106781;
            5:       n = 64'd555570233;
            6:       n = 64'd382683432;
            7:       n = 64'd195090322;
            default: n = 64'd0;
        endcase
        return ((longint'(1) << (COEF_FRAC - 1)) * n + 64'd500000000) / 64'd1000000000;
    endfunction

    // C[u][x] at index u*8+x; cos((2x+1)u*pi/16) folded onto m in 0..8 with a sign.
    function automatic logic [63:0][CW-1:0] build_rom();
        logic [63:0][CW-1:0] t;
        int     a, m;
        logic   neg;
        longint mag;
        t = '0;
        for (int u = 0; u < 8; u++) begin
            for (int x = 0; x < 8; x++) begin
                if (u == 0) begin
                    m = 4;
                    neg = 1'b0;
                end else begin
                    a = ((2 * x + 1) * u) % 32;
                    if (a > 16) a = 32 - a;
                    if (a > 8) begin
                        m = 16 - a;
                        neg = 1'b1;
                    end else begin
                        m = a;
                        neg = 1'b0;
                    end
                end
                mag = cmag(m);
                t[u*8+x] = neg ? CW'(-mag) : CW'(mag);
            end
        end
        return t;
    endfunction

    localparam logic [63:0][CW-1:0] ROM = build_rom();

    localparam logic [0:63][5:0] ZZ = {
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};

    localparam logic [0:63][6:0] QB = {
        7'd16, 7'd11, 7'd10, 7'd16, 7'd24,  7'd40,  7'd51,  7'd61,
        7'd12, 7'd12, 7'd14, 7'd19, 7'd26,  7'd58,  7'd60,  7'd55,
        7'd14, 7'd13, 7'd16, 7'd24, 7'd40,  7'd57,  7'd69,  7'd56,
        7'd14, 7'd17, 7'd22, 7'd29, 7'd51,  7'd87,  7'd80,  7'd62,
        7'd18, 7'd22, 7'd37, 7'd56, 7'd68,  7'd109, 7'd103, 7'd77,
        7'd24, 7'd35, 7'd55, 7'd64, 7'd81,  7'd104, 7'd113, 7'd92,
        7'd49, 7'd64, 7'd78, 7'd87, 7'd103, 7'd121, 7'd120, 7'd101,
        7'd72, 7'd92, 7'd95, 7'd98, 7'd112, 7'd100, 7'd103, 7'd99};

    typedef enum logic [1:0] {LOAD, ROW, COL, DRAIN} state_t;

    state_t state_q, state_d;
    logic [5:0] cnt;
    logic       cnt_inc, load_beat, fire;
    logic       qe_q, zz_q;
    logic [7:0] qs_q;

    logic signed [DW_IN-1:0] smp [64];
    logic signed [RW-1:0]    rr  [64];
    logic signed [XW-1:0]    xx  [64];

    logic signed [RW-1:0] opd [8];
    logic signed [CW-1:0] cf  [8];
    logic signed [AW-1:0] acc;
    logic signed [XW-1:0] rnd;

    logic [5:0]               pos;
    int                       qdiv, val;
    logic signed [DW_OUT-1:0] beat;
    logic                     ov, ol;
    logic signed [DW_OUT-1:0] od;

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = ov;
    assign bus.out_last  = ol;
    assign bus.out_data  = od;
    assign fire          = ov && bus.out_ready;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    // Next state, counter advance and output-beat load decision
    always_comb begin
        state_d   = state_q;
        cnt_inc   = 1'b0;
        load_beat = 1'b0;
        case (state_q)
            LOAD: if (bus.in_valid) begin
                cnt_inc = 1'b1;
                if (cnt == 6'd63) state_d = ROW;
            end
            ROW: begin
                cnt_inc = 1'b1;
                if (cnt == 6'd63) state_d = COL;
            end
            COL: begin
                cnt_inc = 1'b1;
                if (cnt == 6'd63) state_d = DRAIN;
            end
            default: begin
                // Refill the output register when empty or consumed, unless the
                // consumed beat was the last one of the block.
                load_beat = (!ov || bus.out_ready) && !(ov && ol);
                cnt_inc   = load_beat;
                if (fire && ol) state_d = LOAD;
            end
        endcase
    end

    // Shared index: sample idx in LOAD, (row,freq) in ROW/COL, beat k in DRAIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cnt <= '0;
        else if (cnt_inc) cnt <= cnt + 6'd1;
    end

    // Mode pins are captured with the first accepted sample only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qe_q <= 1'b0;
            zz_q <= 1'b0;
            qs_q <= '0;
        end else if (state_q == LOAD && bus.in_valid && cnt == 6'd0) begin
            qe_q <= bus.quant_en;
            zz_q <= bus.zigzag_en;
            qs_q <= bus.qscale;
        end
    end

    // One 8-tap dot product per cycle: along a sample row in ROW, down a
    // column of row results in COL; round-half-up then arithmetic shift.
    always_comb begin
        acc = '0;
        for (int x = 0; x < 8; x++) begin
            if (state_q == COL) begin
                opd[x] = rr[{3'(x), cnt[2:0]}];
                cf[x]  = $signed(ROM[{cnt[5:3], 3'(x)}]);
            end else begin
                opd[x] = RW'(smp[{cnt[5:3], 3'(x)}]);
                cf[x]  = $signed(ROM[{cnt[2:0], 3'(x)}]);
            end
            acc = acc + AW'(opd[x]) * AW'(cf[x]);
        end
        rnd = XW'((acc + AW'(HALF)) >>> COEF_FRAC);
    end

    // Sample, row-result and coefficient stores
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                smp[i] <= '0;
                rr[i]  <= '0;
                xx[i]  <= '0;
            end
        end else begin
            if (state_q == LOAD && bus.in_valid) smp[cnt] <= bus.in_data;
            if (state_q == ROW)                  rr[cnt]  <= rnd[RW-1:0];
            if (state_q == COL)                  xx[cnt]  <= rnd;
        end
    end

    // Drain beat: reorder, optional quantise (truncating divide), saturate
    always_comb begin
        pos  = zz_q ? ZZ[cnt] : cnt;
        qdiv = (int'(QB[pos]) * int'(qs_q) + 32) >> 6;
        if (qdiv < 1) qdiv = 1;
        val = int'(xx[pos]);
        if (qe_q) val = val / qdiv;
        if (val > SMAX)      val = SMAX;
        else if (val < SMIN) val = SMIN;
        beat = DW_OUT'(val);
    end

    // Registered output stage; holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov <= 1'b0;
            ol <= 1'b0;
            od <= '0;
        end else if (load_beat) begin
            ov <= 1'b1;
            ol <= (cnt == 6'd63);
            od <= beat;
        end else if (fire && ol) begin
            ov <= 1'b0;
            ol <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dct2d_quant_stream.sv
// Randomised scoreboard bench for dct2d_quant_stream against a real-valued
// cosine / integer-arithmetic reference model.
module tb_dct2d_quant_stream;
    localparam int DW_IN = 10;
    localparam int CF    = 12;
    localparam real PI   = 3.14159265358979323846;

    typedef int blk_t [64];
    typedef struct { int data; bit last; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dct2d_quant_stream_if #(.DW_IN(DW_IN), .DW_OUT(12)) bus ();
    dct2d_quant_stream_if #(.DW_IN(DW_IN), .DW_OUT(10)) bus2 ();

    dct2d_quant_stream #(.DW_IN(DW_IN), .DW_OUT(12), .COEF_FRAC(CF)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    dct2d_quant_stream #(.DW_IN(DW_IN), .DW_OUT(10), .COEF_FRAC(CF)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus2));

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    bit   rand_ready = 1'b0;
    int   cmat [8][8];
    int   zz [64];
    int   qb [64] = '{16, 11, 10, 16, 24, 40, 51, 61,
                      12, 12, 14, 19, 26, 58, 60, 55,
                      14, 13, 16, 24, 40, 57, 69, 56,
                      14, 17, 22, 29, 51, 87, 80, 62,
                      18, 22, 37, 56, 68, 109, 103, 77,
                      24, 35, 55, 64, 81, 104, 113, 92,
                      49, 64, 78, 87, 103, 121, 120, 101,
                      72, 92, 95, 98, 112, 100, 103, 99};

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic void init_tables();
        int k = 0;
        for (int u = 0; u < 8; u++)
            for (int x = 0; x < 8; x++) begin
                real v = (2.0 ** CF) / 2.0 * ((u == 0) ? 1.0 / $sqrt(2.0) : 1.0)
                         * $cos((2.0 * x + 1.0) * u * PI / 16.0);
                cmat[u][x] = (v >= 0.0) ? $rtoi($floor(v + 0.5)) : -$rtoi($floor(-v + 0.5));
            end
        // Walk the anti-diagonals, alternating direction
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
            end
        end
    endfunction

    function automatic void model(input blk_t s, input bit qe, input bit ze,
                                  input int qs, input int dwo, output blk_t res);
        longint r [64];
        longint xv [64];
        longint acc, v, q, hi, lo;
        for (int y = 0; y < 8; y++)
            for (int u = 0; u < 8; u++) begin
                acc = 0;
                for (int x = 0; x < 8; x++) acc += longint'(cmat[u][x]) * longint'(s[y*8+x]);
                r[y*8+u] = (acc + (longint'(1) << (CF - 1))) >>> CF;
            end
        for (int vv = 0; vv < 8; vv++)
            for (int u = 0; u < 8; u++) begin
                acc = 0;
                for (int y = 0; y < 8; y++) acc += longint'(cmat[vv][y]) * r[y*8+u];
                xv[vv*8+u] = (acc + (longint'(1) << (CF - 1))) >>> CF;
            end
        hi = (longint'(1) << (dwo - 1)) - 1;
        lo = -(longint'(1) << (dwo - 1));
        for (int k = 0; k < 64; k++) begin
            int p = ze ? zz[k] : k;
            v = xv[p];
            if (qe) begin
                q = (longint'(qb[p]) * qs + 32) / 64;
                if (q < 1) q = 1;
                v = v / q;
            end
            if (v > hi) v = hi;
            if (v < lo) v = lo;
            res[k] = int'(v);
        end
    endfunction

    task automatic send_block(input blk_t b, input bit qe, input bit ze, input int qs,
                              input bit gaps, input bit scramble, input bit push);
        int   n = 0;
        blk_t res;
        while (!bus.in_ready && n < 2000) begin @(posedge clk); #1; n++; end
        check("in_ready_wait", int'(bus.in_ready), 1);
        for (int i = 0; i < 64; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = DW_IN'(b[i]);
            if (i == 0 || !scramble) begin
                bus.quant_en  = qe;
                bus.zigzag_en = ze;
                bus.qscale    = 8'(qs);
            end else begin
                bus.quant_en  = 1'($urandom_range(1));
                bus.zigzag_en = 1'($urandom_range(1));
                bus.qscale    = 8'($urandom_range(255));
            end
            if (i == 0 || i == 63) check("in_ready_load", int'(bus.in_ready), 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (push) begin
            model(b, qe, ze, qs, 12, res);
            for (int k = 0; k < 64; k++) exp_q.push_back('{res[k], k == 63});
        end
    endtask

    // Downstream ready: always 1 or random per cycle
    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_ready ? ($urandom_range(1) == 1) : 1'b1;
    end

    // Monitor: pop expected beats on handshakes, check stability while stalled
    initial begin
        bit   stalled = 1'b0;
        int   held_d = 0;
        int   held_l = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin stalled = 1'b0; continue; end
            if (bus.out_valid && stalled) begin
                check("stall_hold_data", int'(bus.out_data), held_d);
                check("stall_hold_last", int'(bus.out_last), held_l);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_beat", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    check("beat_data", int'(bus.out_data), e.data);
                    check("beat_last", int'(bus.out_last), int'(e.last));
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            held_d  = int'(bus.out_data);
            held_l  = int'(bus.out_last);
        end
    end

    initial begin
        blk_t b, res2;
        int   n, k;
        init_tables();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.quant_en = 1'b0;
        bus.zigzag_en = 1'b0; bus.qscale = '0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.quant_en = 1'b0;
        bus2.zigzag_en = 1'b0; bus2.qscale = 8'd64; bus2.out_ready = 1'b1;

        // Asynchronous reset before any clock edge
        #3 rst = 1'b1;
        #1;
        check("reset_in_ready", int'(bus.in_ready), 1);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out_data", int'(bus.out_data), 0);
        check("reset_out_last", int'(bus.out_last), 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // Saturation on the narrow-output instance
        for (int i = 0; i < 64; i++) begin
            bus2.in_valid = 1'b1; bus2.in_data = 10'sd200; b[i] = 200;
            @(posedge clk); #1;
        end
        bus2.in_valid = 1'b0;
        model(b, 1'b0, 1'b0, 64, 10, res2);
        k = 0; n = 0;
        while (k < 64 && n < 600) begin
            @(negedge clk); n++;
            if (bus2.out_valid) begin
                check("sat_beat", int'(bus2.out_data), res2[k]);
                check("sat_last", int'(bus2.out_last), int'(k == 63));
                if (k == 0) check("sat_beat0", int'(bus2.out_data), 511);
                k++;
            end
        end
        check("sat_beat_count", k, 64);

        // Constant block, raw mode, with first-output latency
        for (int i = 0; i < 64; i++) b[i] = 100;
        send_block(b, 1'b0, 1'b0, 64, 1'b0, 1'b0, 1'b1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.out_valid && n < 400);
        check("first_out_latency", n, 129);
        check("beat0_raw_const", int'(bus.out_data), 800);

        // Constant block quantised: nominal scale, then scale 0 (Q clamps to 1)
        send_block(b, 1'b1, 1'b0, 64, 1'b0, 1'b0, 1'b1);
        send_block(b, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Pseudo-random block, raster then zigzag
        for (int i = 0; i < 64; i++) b[i] = int'($urandom_range(1023)) - 512;
        send_block(b, 1'b0, 1'b0, 64, 1'b0, 1'b0, 1'b1);
        send_block(b, 1'b0, 1'b1, 64, 1'b0, 1'b0, 1'b1);

        // Random stalls, input gaps, mid-block mode pin changes
        rand_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 64; i++) b[i] = int'($urandom_range(1023)) - 512;
            send_block(b, 1'($urandom_range(1)), 1'($urandom_range(1)),
                       int'($urandom_range(255)), 1'b1, 1'b1, 1'b1);
        end

        // Abort during the column pass
        rand_ready = 1'b0;
        for (int i = 0; i < 64; i++) b[i] = int'($urandom_range(1023)) - 512;
        send_block(b, 1'b0, 1'b0, 64, 1'b0, 1'b0, 1'b0);
        check("in_ready_low_busy", int'(bus.in_ready), 0);
        repeat (80) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_in_ready", int'(bus.in_ready), 1);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_out_data", int'(bus.out_data), 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 64; i++) b[i] = int'($urandom_range(1023)) - 512;
        send_block(b, 1'b1, 1'b1, 64, 1'b1, 1'b0, 1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
        check("drain_complete", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
